muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. It takes operands read from the register file (rd1/rd2), computes one of the eight M-extension results over multiple cycles, and returns the result plus destination index to the register-file write port (writedata/rd/regwrite). It sits between operand read and writeback in the core, next to the single-cycle ALU.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while idle
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  WIDTH  rs1 value (register-file rd1)
op_b  input  WIDTH  rs2 value (register-file rd2)
rd_in  input  REG_ADDR_W  destination register index
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: result valid
result  output  WIDTH  computed value (to writedata); held until next done
rd_out  output  REG_ADDR_W  captured rd_in (to rd); held with result
regwrite_out  output  1  done && (rd_out != 0) (to regwrite)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy 0, done 0, result 0, rd_out 0, regwrite_out 0, internal counter/accumulators 0. Reset mid-operation aborts silently; no done is produced.
- States: IDLE, CALC, FIX. done is a registered flag.
- IDLE: at edge E0 with start=1, capture funct3, rd_in, operand magnitudes and sign flags; counter=0. Normal case -> CALC. Fast-path cases (below) -> FIX with result preset.
- CALC: one iteration per edge. Multiply: shift-add on a 2*WIDTH product register. Divide: restoring, one quotient bit per edge. After WIDTH iterations (edges E1..E32) -> FIX.
- FIX: at next edge (E33), apply sign correction and select result, load result/rd_out, set done=1, go to IDLE. done clears at the following edge.
- Latency: normal ops, done high in cycle after E33 (33 edges after accept). Fast path: done high in cycle after E1.
- start while busy: ignored; no queuing. start in the same cycle done is high: accepted (state already IDLE).
- Operands are captured at accept. Later changes to op_a/op_b/funct3/rd_in have no effect.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: both unsigned. Iterations operate on magnitudes.
  - Product is negated in FIX if operand signs differ (signed operands only).
  - Quotient is negated if signs differ. Remainder takes the sign of the dividend.
- Result select: MUL = product[WIDTH-1:0]; MULH/MULHSU/MULHU = product[2*WIDTH-1:WIDTH].
- Fast path, all per RISC-V spec:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (DIV/REM with op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- regwrite_out never asserts for rd_out = 0. result still updates in that case.
- result/rd_out hold their value between done pulses.

Test Plan:
- Reset: assert rst_n=0 mid-CALC after a start -> busy, done, result, rd_out go 0 immediately; no done pulse after release.
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd=5 -> done one cycle, 33 edges after accept; result 0xFFFFFFEB; rd_out=5; regwrite_out=1.
- MULH/MULHSU/MULHU with a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero, a=0x1234: DIV -> 0xFFFFFFFF, REM -> 0x1234, done after 1 edge. Overflow DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- Back-to-back start held high: second op accepted on the edge after done. A start pulsed while busy produces no extra done. rd=0 gives done=1 with regwrite_out=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide over
// WIDTH cycles on operand magnitudes, followed by a sign-fix cycle that drives writeback.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  regwrite_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                  state, state_next;
  logic [2:0]              op_reg;
  logic [REG_ADDR_W-1:0]   rd_reg;
  logic [WIDTH-1:0]        op_mag;
  logic [2*WIDTH-1:0]      acc;
  logic                    sgn_a, sgn_b;
  logic                    fast_reg;
  logic [WIDTH-1:0]        preset_val;
  logic [CNT_W-1:0]        count;

  logic                    is_div, signed_a, signed_b, neg_a, neg_b;
  logic [WIDTH-1:0]        mag_a, mag_b;
  logic                    div_zero, div_ovf, fast;
  logic [WIDTH-1:0]        fast_val;
  logic                    last_iter;

  logic [WIDTH:0]          mul_sum;
  logic [2*WIDTH-1:0]      mul_next;
  logic [WIDTH:0]          div_shift, div_diff;
  logic [2*WIDTH-1:0]      div_next;
  logic [2*WIDTH-1:0]      prod_fix;
  logic [WIDTH-1:0]        quo_fix, rem_fix, fix_val;

  // Operand decode at accept: signedness per op, magnitudes, and the results that skip iteration
  always_comb begin
    is_div   = funct3[2];
    signed_a = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = signed_a && op_a[WIDTH-1];
    neg_b    = signed_b && op_b[WIDTH-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
    fast     = div_zero || div_ovf;
    fast_val = '0;
    if (div_zero)
      fast_val = funct3[1] ? op_a : '1;
    else if (div_ovf)
      fast_val = funct3[1] ? '0 : op_a;
  end

  // acc holds {hi, lo} of the product, or {remainder, dividend/quotient} when dividing
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_mag} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_mag};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    last_iter = (count == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    prod_fix = (sgn_a ^ sgn_b) ? -acc : acc;
    quo_fix  = (sgn_a ^ sgn_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sgn_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_val  = rem_fix;
    if (fast_reg)
      fix_val = preset_val;
    else begin
      case (op_reg)
        3'b000:                 fix_val = prod_fix[WIDTH-1:0];
        3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
        3'b100, 3'b101:         fix_val = quo_fix;
        default:                fix_val = rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = fast ? FIX : CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    regwrite_out = done && (rd_out != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      rd_reg     <= '0;
      op_mag     <= '0;
      acc        <= '0;
      sgn_a      <= 1'b0;
      sgn_b      <= 1'b0;
      fast_reg   <= 1'b0;
      preset_val <= '0;
      count      <= '0;
      done       <= 1'b0;
      result     <= '0;
      rd_out     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_reg     <= funct3;
          rd_reg     <= rd_in;
          sgn_a      <= neg_a;
          sgn_b      <= neg_b;
          op_mag     <= is_div ? mag_b : mag_a;
          acc        <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          fast_reg   <= fast;
          preset_val <= fast_val;
          count      <= '0;
        end
        CALC: begin
          acc   <= op_reg[2] ? div_next : mul_next;
          count <= count + CNT_W'(1);
        end
        FIX: begin
          result <= fix_val;
          rd_out <= rd_reg;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected result/rd/latency,
// a negedge monitor pops and checks on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, regwrite_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out),
    .regwrite_out(regwrite_out)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt++;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cycle_cnt);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done=1 expected none pending (cycle %0d)", cycle_cnt);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result", result, mon_e.res);
        checkOutput("rd_out", 32'(rd_out), 32'(mon_e.rd));
        checkOutput("regwrite_out", 32'(regwrite_out), 32'(mon_e.rw));
        checkOutput("latency", 32'(cycle_cnt), 32'(mon_e.cyc));
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic pushExp(input logic [31:0] res, input logic [4:0] rd, input int cyc);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    e.rw  = (rd != 5'd0);
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Called at a negedge; issues one op and scrambles inputs after accept
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] exp_res, input bit is_fast);
    waitIdle();
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    start  = 1'b1;
    pushExp(exp_res, rd, cycle_cnt + 1 + (is_fast ? 1 : 33));
    @(negedge clk);
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom);
    rd_in  = 5'($urandom);
  endtask

  initial begin
    int base;
    int n;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_rd_out", 32'(rd_out), 32'(0));
    checkOutput("reset_regwrite", 32'(regwrite_out), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b0);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0);
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 1'b0);
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'b101, 32'd100,       32'd7,         5'd7,  32'd14,        1'b0);
    applyStimulus(3'b111, 32'd100,       32'd7,         5'd8,  32'd2,         1'b0);
    applyStimulus(3'b100, 32'h0000_1234, 32'h0,         5'd11, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(3'b110, 32'h0000_1234, 32'h0,         5'd12, 32'h0000_1234, 1'b1);
    applyStimulus(3'b101, 32'h0000_1234, 32'h0,         5'd13, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(3'b111, 32'h0000_1234, 32'h0,         5'd14, 32'h0000_1234, 1'b1);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1'b1);
    applyStimulus(3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        1'b0);
    applyStimulus(3'b001, 32'hFFFF_FFFE, 32'd3,         5'd17, 32'hFFFF_FFFF, 1'b0);

    // A start pulse while busy must be dropped without a second done
    applyStimulus(3'b000, 32'd123, 32'd456, 5'd18, 32'h0000_DB18, 1'b0);
    repeat (3) @(negedge clk);
    funct3 = 3'b100; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd19; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // start held high: second op is taken on the edge right after done
    waitIdle();
    base   = cycle_cnt;
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
    pushExp(32'd14, 5'd9, base + 34);
    @(negedge clk);
    funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd10;
    pushExp(32'hFFFF_FFFE, 5'd10, base + 68);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("held_done_timeout", 32'(done), 32'(1));
    @(negedge clk);
    start = 1'b0;

    // Mid-operation reset: outputs clear at once and the aborted op never completes
    waitIdle();
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'd9; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    checkOutput("abort_result", result, 32'h0);
    checkOutput("abort_rd_out", 32'(rd_out), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    applyStimulus(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drain", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
